bnn_param_loader: RTL

BNN_PARAM_LOADER -- requirements
Module: bnn_param_loader

---
 rtl/bnn_param_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bnn_param_loader.sv
// bnn_param_loader: streams host bytes MSB-first into a serial BNN neuron parameter chain.
// Define PARAM_CHECKSUM_EN to require a trailing XOR checksum byte after each load.
module bnn_param_loader #(
  parameter int CHAIN_BITS = 88
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       setup,
  output logic       param_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
`ifdef PARAM_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t     state;
  logic [7:0] shift_reg;
  logic [9:0] remaining;
  logic [3:0] bit_cnt;
  logic [3:0] first_cnt;

`ifdef PARAM_CHECKSUM_EN
  logic       err_q;
  logic [7:0] checksum;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // A final partial byte only contributes its upper bits to the chain.
  assign first_cnt = (remaining >= 10'd8) ? 4'd8 : remaining[3:0];
  assign param_out = setup & shift_reg[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      setup     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_reg <= '0;
      remaining <= '0;
      bit_cnt   <= '0;
`ifdef PARAM_CHECKSUM_EN
      err_q     <= 1'b0;
      checksum  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state    <= IDLE;
        in_ready <= 1'b0;
        setup    <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state     <= LOAD;
              remaining <= 10'(CHAIN_BITS);
              in_ready  <= 1'b1;
              busy      <= 1'b1;
`ifdef PARAM_CHECKSUM_EN
              err_q     <= 1'b0;
              checksum  <= '0;
`endif
            end
          end
          LOAD: begin
            if (in_valid) begin
              shift_reg <= in_data;
              bit_cnt   <= first_cnt;
              in_ready  <= 1'b0;
              setup     <= 1'b1;
              state     <= SHIFT;
`ifdef PARAM_CHECKSUM_EN
              checksum  <= checksum ^ in_data;
`endif
            end
          end
          SHIFT: begin
            shift_reg <= {shift_reg[6:0], 1'b0};
            bit_cnt   <= bit_cnt - 1'b1;
            remaining <= remaining - 1'b1;
            if (bit_cnt == 4'd1) begin
              setup <= 1'b0;
              if (remaining != 10'd1) begin
                state    <= LOAD;
                in_ready <= 1'b1;
              end else begin
`ifdef PARAM_CHECKSUM_EN
                state    <= CHECK;
                in_ready <= 1'b1;
`else
                state    <= DONE;
                done     <= 1'b1;
`endif
              end
            end
          end
`ifdef PARAM_CHECKSUM_EN
          CHECK: begin
            if (in_valid) begin
              if (in_data != checksum) err_q <= 1'b1;
              in_ready <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
`endif
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
